// File: rtl/lif_cfg_pkg.sv
// Shared types and constants for the LIF configuration sequencer.
// Optional feature macro: LIF_CFG_PARITY_EN (appends an even-parity bit to each frame).
package lif_cfg_pkg;

    // Default frame geometry: four 8-bit neuron parameters
    localparam int LIF_PARAM_W_DEF    = 8;
    localparam int LIF_NUM_PARAMS_DEF = 4;

    // Word positions inside a configuration frame (word 0 at the LSBs)
    localparam int IDX_WA   = 0;
    localparam int IDX_WB   = 1;
    localparam int IDX_LEAK = 2;
    localparam int IDX_THR  = 3;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RDY = 2'd2,
        RUN      = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/lif_cfg_shifter.sv
// Loadable parallel-in/serial-out shifter for one configuration frame.
// Bits leave word 0 first, MSB first within each word. When LIF_CFG_PARITY_EN
// is defined, an even-parity bit over all data bits follows the last data bit.
// The serial output is taken straight from the top flop, so it is registered,
// and zeros are shifted in so the line idles low once the frame has gone out.
module lif_cfg_shifter
    import lif_cfg_pkg::*;
#(
    parameter int PARAM_W    = LIF_PARAM_W_DEF,
    parameter int NUM_PARAMS = LIF_NUM_PARAMS_DEF
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          load_i,
    input  logic                          shift_en_i,
    input  logic [PARAM_W*NUM_PARAMS-1:0] frame_i,
    output logic                          serial_o,
    output logic                          last_o
);

    localparam int DATA_BITS = PARAM_W * NUM_PARAMS;
`ifdef LIF_CFG_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 1;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic [FRAME_BITS-1:0] frame_ordered;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Stream position gi maps to word gi/PARAM_W, bit (PARAM_W-1 - gi%PARAM_W);
    // stream position 0 sits at the MSB of the shift register.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_order
            assign frame_ordered[FRAME_BITS-1-gi] =
                frame_i[(gi / PARAM_W) * PARAM_W + (PARAM_W - 1 - (gi % PARAM_W))];
        end
    endgenerate

`ifdef LIF_CFG_PARITY_EN
    assign frame_ordered[0] = ^frame_i;
`endif

    // Next-state: load a new frame, or shift one bit out and count it
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = frame_ordered;
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Shift register and bit counter
    always_ff @(posedge clk) begin
        if (srst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign serial_o = sr_q[FRAME_BITS-1];
    assign last_o   = (cnt_q == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/lif_cfg_sequencer.sv
// Configuration sequencer for the dual-channel LIF neuron system: accepts a
// host frame, streams it to the neuron, waits for params_ready with a timeout,
// then gates neuron operation with run_en.
// Optional feature macro: LIF_CFG_PARITY_EN (parity bit appended by the shifter).
module lif_cfg_sequencer
    import lif_cfg_pkg::*;
#(
    parameter int PARAM_W    = LIF_PARAM_W_DEF,
    parameter int NUM_PARAMS = LIF_NUM_PARAMS_DEF,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [PARAM_W*NUM_PARAMS-1:0] cfg_data,
    input  logic                          run_en,
    input  logic                          params_ready,
    output logic                          load_mode,
    output logic                          serial_data,
    output logic                          input_enable,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1
    localparam int TO_W = $clog2(TIMEOUT + 1);

    cfg_state_e      state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            cfg_ready_q, cfg_ready_d;
    logic            load_mode_q, load_mode_d;
    logic            input_enable_q, input_enable_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cfg_err_q, cfg_err_d;

    logic            accept;
    logic            shift_en;
    logic            last_bit;

    lif_cfg_shifter #(
        .PARAM_W    (PARAM_W),
        .NUM_PARAMS (NUM_PARAMS)
    ) u_shifter (
        .clk        (clk),
        .srst       (reset),
        .load_i     (accept),
        .shift_en_i (shift_en),
        .frame_i    (cfg_data),
        .serial_o   (serial_data),
        .last_o     (last_bit)
    );

    // Next-state logic; registered outputs are derived from the next state
    always_comb begin
        state_d        = state_q;
        to_d           = to_q;
        cfg_err_d      = cfg_err_q;
        done_d         = 1'b0;
        input_enable_d = 1'b0;
        accept         = 1'b0;
        shift_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    accept    = 1'b1;
                    cfg_err_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_d = WAIT_RDY;
                    to_d    = '0;
                end
            end
            WAIT_RDY: begin
                // params_ready takes priority over a coincident timeout
                if (params_ready) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    cfg_err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            RUN: begin
                // A new frame (reconfiguration) wins over a falling params_ready
                if (cfg_valid && cfg_ready_q) begin
                    accept    = 1'b1;
                    cfg_err_d = 1'b0;
                    state_d   = SHIFT;
                end else if (!params_ready) begin
                    state_d = IDLE;
                end else begin
                    input_enable_d = run_en;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cfg_ready_d = (state_d == IDLE) || (state_d == RUN);
        busy_d      = (state_d == SHIFT) || (state_d == WAIT_RDY);
        load_mode_d = (state_d == SHIFT);
    end

    // State, timeout counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            to_q           <= '0;
            cfg_ready_q    <= 1'b1;
            load_mode_q    <= 1'b0;
            input_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            to_q           <= to_d;
            cfg_ready_q    <= cfg_ready_d;
            load_mode_q    <= load_mode_d;
            input_enable_q <= input_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign load_mode    = load_mode_q;
    assign input_enable = input_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_lif_cfg_sequencer.sv
// Directed testbench for lif_cfg_sequencer. Output bundle order used in the
// checks: {cfg_ready, load_mode, serial_data, input_enable, busy, done, cfg_err}.
// Honours LIF_CFG_PARITY_EN when defined.
module tb_lif_cfg_sequencer;

    localparam int PW = 8;
    localparam int NP = 4;
    localparam int TO = 64;
`ifdef LIF_CFG_PARITY_EN
    localparam int FRAME_BITS = 33;
    localparam logic [63:0] EXP_12345678 = 64'hF0AC_6825;
    localparam logic [63:0] EXP_00000001 = 64'h0200_0001;
    localparam logic [63:0] EXP_00000003 = 64'h0600_0000;
`else
    localparam int FRAME_BITS = 32;
    localparam logic [63:0] EXP_12345678 = 64'h7856_3412;
    localparam logic [63:0] EXP_00000001 = 64'h0100_0000;
    localparam logic [63:0] EXP_00000003 = 64'h0300_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        run_en = 1'b0;
    logic        params_ready = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        cfg_ready, load_mode, serial_data, input_enable, busy, done, cfg_err;
    wire  [6:0]  outs = {cfg_ready, load_mode, serial_data, input_enable, busy, done, cfg_err};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lif_cfg_sequencer #(
        .PARAM_W    (PW),
        .NUM_PARAMS (NP),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .run_en       (run_en),
        .params_ready (params_ready),
        .load_mode    (load_mode),
        .serial_data  (serial_data),
        .input_enable (input_enable),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    function automatic logic [31:0] mk_frame(input logic [7:0] wa, input logic [7:0] wb,
                                             input logic [7:0] lk, input logic [7:0] th);
        logic [31:0] f;
        f = '0;
        f[lif_cfg_pkg::IDX_WA*8 +: 8]   = wa;
        f[lif_cfg_pkg::IDX_WB*8 +: 8]   = wb;
        f[lif_cfg_pkg::IDX_LEAK*8 +: 8] = lk;
        f[lif_cfg_pkg::IDX_THR*8 +: 8]  = th;
        return f;
    endfunction

    // Reference bitstream: word 0 first, MSB first, optional parity last
    function automatic logic [63:0] exp_stream(input logic [31:0] f);
        logic [63:0] s;
        s = '0;
        for (int w = 0; w < 4; w++)
            for (int b = 7; b >= 0; b--)
                s = {s[62:0], f[w*8+b]};
`ifdef LIF_CFG_PARITY_EN
        s = {s[62:0], ^f};
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [31:0] f);
        cfg_data  = f;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Record serial_data while load_mode is high (bounded)
    task automatic collect(output int n, output logic [63:0] s, output bit bad);
        n = 0;
        s = '0;
        bad = 1'b0;
        while (load_mode === 1'b1 && n < 100) begin
            s = {s[62:0], serial_data};
            if (cfg_ready !== 1'b0 || busy !== 1'b1 || input_enable !== 1'b0) bad = 1'b1;
            n++;
            tick();
        end
    endtask

    task automatic finish_to_idle();
        params_ready = 1'b1;
        tick();
        params_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        vectors++; if (outs !== 7'b1000000) begin miscompares++; $display("FAIL reset_held: got %b expected %b", outs, 7'b1000000); end
        reset = 1'b0;
        tick();
        vectors++; if (outs !== 7'b1000000) begin miscompares++; $display("FAIL reset_release: got %b expected %b", outs, 7'b1000000); end
        $display("reset: outs=%b", outs);
    endtask

    task automatic test_first_frame();
        int n; logic [63:0] s; bit bad;
        handshake(mk_frame(8'h78, 8'h56, 8'h34, 8'h12));
        collect(n, s, bad);
        vectors++; if (n !== FRAME_BITS) begin miscompares++; $display("FAIL load_cycles: got %0d expected %0d", n, FRAME_BITS); end
        vectors++; if (s !== EXP_12345678) begin miscompares++; $display("FAIL stream_12345678: got %h expected %h", s, EXP_12345678); end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL shift_flags: got %b expected %b", bad, 1'b0); end
        vectors++; if (outs !== 7'b0000100) begin miscompares++; $display("FAIL wait_entry: got %b expected %b", outs, 7'b0000100); end
        $display("frame 12345678: %0d bits, stream=%h", n, s);
    endtask

    task automatic test_params_ready();
        tick();
        tick();
        vectors++; if (outs !== 7'b0000100) begin miscompares++; $display("FAIL wait_hold: got %b expected %b", outs, 7'b0000100); end
        params_ready = 1'b1;
        run_en = 1'b1;
        tick();
        vectors++; if (outs !== 7'b1000010) begin miscompares++; $display("FAIL run_entry: got %b expected %b", outs, 7'b1000010); end
        tick();
        vectors++; if (outs !== 7'b1001000) begin miscompares++; $display("FAIL enable_on: got %b expected %b", outs, 7'b1001000); end
        run_en = 1'b0;
        tick();
        vectors++; if (outs !== 7'b1000000) begin miscompares++; $display("FAIL run_en_low: got %b expected %b", outs, 7'b1000000); end
        run_en = 1'b1;
        tick();
        vectors++; if (outs !== 7'b1001000) begin miscompares++; $display("FAIL run_en_high: got %b expected %b", outs, 7'b1001000); end
        $display("params_ready: run entered, outs=%b", outs);
    endtask

    task automatic test_reconfig();
        int n; logic [63:0] s; bit bad;
        logic [31:0] f;
        f = 32'hA5C3_0FF0;
        cfg_data = f;
        cfg_valid = 1'b1;
        params_ready = 1'b0;
        tick();
        cfg_valid = 1'b0;
        vectors++; if (outs !== 7'b0110100) begin miscompares++; $display("FAIL reconfig_entry: got %b expected %b", outs, 7'b0110100); end
        collect(n, s, bad);
        vectors++; if (n !== FRAME_BITS) begin miscompares++; $display("FAIL reconfig_cycles: got %0d expected %0d", n, FRAME_BITS); end
        vectors++; if (s !== exp_stream(f)) begin miscompares++; $display("FAIL reconfig_stream: got %h expected %h", s, exp_stream(f)); end
        $display("reconfig %h: %0d bits, stream=%h", f, n, s);
    endtask

    task automatic test_params_fall();
        params_ready = 1'b1;
        tick();
        tick();
        vectors++; if (outs !== 7'b1001000) begin miscompares++; $display("FAIL rerun_enable: got %b expected %b", outs, 7'b1001000); end
        params_ready = 1'b0;
        tick();
        vectors++; if (outs !== 7'b1000000) begin miscompares++; $display("FAIL params_fall: got %b expected %b", outs, 7'b1000000); end
        params_ready = 1'b1;
        tick();
        tick();
        vectors++; if (outs !== 7'b1000000) begin miscompares++; $display("FAIL idle_after_fall: got %b expected %b", outs, 7'b1000000); end
        params_ready = 1'b0;
        tick();
        $display("params_fall: outs=%b", outs);
    endtask

    task automatic test_timeout();
        int n; logic [63:0] s; bit bad;
        handshake(32'h0F0F_0F0F);
        collect(n, s, bad);
        vectors++; if (n !== FRAME_BITS) begin miscompares++; $display("FAIL timeout_frame_cycles: got %0d expected %0d", n, FRAME_BITS); end
        repeat (TO - 1) tick();
        vectors++; if (outs !== 7'b0000100) begin miscompares++; $display("FAIL before_timeout: got %b expected %b", outs, 7'b0000100); end
        tick();
        vectors++; if (outs !== 7'b1000001) begin miscompares++; $display("FAIL timeout_err: got %b expected %b", outs, 7'b1000001); end
        repeat (5) tick();
        vectors++; if (outs !== 7'b1000001) begin miscompares++; $display("FAIL err_sticky: got %b expected %b", outs, 7'b1000001); end
        $display("timeout: outs=%b", outs);
    endtask

    task automatic test_reset_mid_shift();
        int n; logic [63:0] s; bit bad;
        handshake(mk_frame(8'h78, 8'h56, 8'h34, 8'h12));
        vectors++; if (outs !== 7'b0100100) begin miscompares++; $display("FAIL err_cleared: got %b expected %b", outs, 7'b0100100); end
        repeat (9) tick();
        vectors++; if (outs !== 7'b0110100) begin miscompares++; $display("FAIL bit9: got %b expected %b", outs, 7'b0110100); end
        tick();
        vectors++; if (outs !== 7'b0100100) begin miscompares++; $display("FAIL bit10: got %b expected %b", outs, 7'b0100100); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (outs !== 7'b1000000) begin miscompares++; $display("FAIL reset_mid_shift: got %b expected %b", outs, 7'b1000000); end
        tick();
        handshake(mk_frame(8'h78, 8'h56, 8'h34, 8'h12));
        collect(n, s, bad);
        vectors++; if (n !== FRAME_BITS) begin miscompares++; $display("FAIL post_reset_cycles: got %0d expected %0d", n, FRAME_BITS); end
        vectors++; if (s !== EXP_12345678) begin miscompares++; $display("FAIL post_reset_stream: got %h expected %h", s, EXP_12345678); end
        finish_to_idle();
        $display("reset_mid_shift: restart stream=%h", s);
    endtask

    task automatic test_ignore_busy();
        int n; logic [63:0] s; bit bad;
        logic [31:0] f;
        f = 32'h8001_7FFE;
        handshake(f);
        cfg_data = 32'h5555_AAAA;
        cfg_valid = 1'b1;
        collect(n, s, bad);
        vectors++; if (s !== exp_stream(f)) begin miscompares++; $display("FAIL ignore_stream: got %h expected %h", s, exp_stream(f)); end
        tick();
        vectors++; if (outs !== 7'b0000100) begin miscompares++; $display("FAIL ignore_wait: got %b expected %b", outs, 7'b0000100); end
        cfg_valid = 1'b0;
        finish_to_idle();
        $display("ignore_busy %h: stream=%h", f, s);
    endtask

    task automatic test_small_frames();
        int n; logic [63:0] s; bit bad;
        handshake(32'h0000_0001);
        collect(n, s, bad);
        vectors++; if (n !== FRAME_BITS) begin miscompares++; $display("FAIL f1_cycles: got %0d expected %0d", n, FRAME_BITS); end
        vectors++; if (s !== EXP_00000001) begin miscompares++; $display("FAIL f1_stream: got %h expected %h", s, EXP_00000001); end
`ifdef LIF_CFG_PARITY_EN
        vectors++; if (s[0] !== 1'b1) begin miscompares++; $display("FAIL f1_parity: got %b expected %b", s[0], 1'b1); end
`endif
        finish_to_idle();
        $display("frame 00000001: %0d bits, stream=%h", n, s);
        handshake(32'h0000_0003);
        collect(n, s, bad);
        vectors++; if (n !== FRAME_BITS) begin miscompares++; $display("FAIL f3_cycles: got %0d expected %0d", n, FRAME_BITS); end
        vectors++; if (s !== EXP_00000003) begin miscompares++; $display("FAIL f3_stream: got %h expected %h", s, EXP_00000003); end
`ifdef LIF_CFG_PARITY_EN
        vectors++; if (s[0] !== 1'b0) begin miscompares++; $display("FAIL f3_parity: got %b expected %b", s[0], 1'b0); end
`endif
        finish_to_idle();
        $display("frame 00000003: %0d bits, stream=%h", n, s);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_params_ready();
        test_reconfig();
        test_params_fall();
        test_timeout();
        test_reset_mid_shift();
        test_ignore_busy();
        test_small_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
